// File: rtl/led_pattern_counter_top.sv
// DE0-Nano LED pattern counter: up/down/bounce/ring display modes cycled by a
// debounced push-button, with a run-enable switch and a tick-stretched wrap LED.
module led_pattern_counter_top #(
    parameter int EXT_CLOCK_FREQ = 50000000,
    parameter int TICK_HZ        = 5,
    parameter int LEDG_SIZE      = 8,
    parameter int DEBOUNCE_MS    = 10,
    parameter int OVF_HOLD_TICKS = 1
) (
    input  logic                 EXTCLK,
    input  logic [1:0]           KEY,
    input  logic                 SW,
    output logic [LEDG_SIZE-1:0] LEDG
);
    localparam int W          = LEDG_SIZE - 1;
    localparam int TICK_DIV   = EXT_CLOCK_FREQ / TICK_HZ;
    localparam int DEB_CYCLES = (EXT_CLOCK_FREQ / 1000) * DEBOUNCE_MS;
    localparam int TC_W       = $clog2(TICK_DIV);
    localparam int DEB_W      = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W     = $clog2(OVF_HOLD_TICKS + 1);

    localparam logic [TC_W-1:0]   TC_ZERO   = {TC_W{1'b0}};
    localparam logic [TC_W-1:0]   TC_LAST   = TC_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_ZERO  = {DEB_W{1'b0}};
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(OVF_HOLD_TICKS);
    localparam logic [W-1:0]      VAL_ZERO  = {W{1'b0}};
    localparam logic [W-1:0]      VAL_MAX   = {W{1'b1}};

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_RING   = 2'd3
    } mode_e;

    logic [1:0]           rst_sync_q, rst_sync_d;
    logic                 rst_n_s;
    logic [1:0]           sw_sync_q, sw_sync_d;
    logic [1:0]           key_sync_q, key_sync_d;
    logic                 sw_s, key_s;
    logic                 deb_level_q, deb_level_d;
    logic [DEB_W-1:0]     deb_cnt_q, deb_cnt_d;
    logic                 press_q, press_d;
    logic [TC_W-1:0]      tc_q, tc_d;
    mode_e                mode_q, mode_d;
    logic [W-1:0]         val_q, val_d;
    logic                 dir_up_q, dir_up_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [LEDG_SIZE-1:0] ledg_q, ledg_d;
    logic [W-1:0]         step_val_s;
    logic                 step_dir_s, wrap_s, go_up_s;

    assign rst_n_s = rst_sync_q[1];
    assign sw_s    = sw_sync_q[1];
    assign key_s   = key_sync_q[1];
    assign LEDG    = ledg_q;

    // Reset synchroniser: clears at once on KEY[0], releases after two edges.
    always_ff @(posedge EXTCLK or negedge KEY[0]) begin
        if (!KEY[0]) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    // Input synchronisers and button debouncer; a press is a settled 1->0.
    always_comb begin
        rst_sync_d  = {rst_sync_q[0], 1'b1};
        sw_sync_d   = {sw_sync_q[0], SW};
        key_sync_d  = {key_sync_q[0], KEY[1]};
        deb_level_d = deb_level_q;
        deb_cnt_d   = DEB_ZERO;
        press_d     = 1'b0;
        if (key_s != deb_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_level_d = key_s;
                press_d     = ~key_s;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end else begin
            deb_cnt_d = DEB_ZERO;
        end
    end

    // Candidate pattern value for the next tick in the current mode.
    always_comb begin
        step_val_s = val_q;
        step_dir_s = dir_up_q;
        wrap_s     = 1'b0;
        go_up_s    = (dir_up_q && (val_q != VAL_MAX)) || (val_q == VAL_ZERO);
        case (mode_q)
            MODE_UP: begin
                step_val_s = val_q + W'(1);
                wrap_s     = (val_q == VAL_MAX);
            end
            MODE_DOWN: begin
                step_val_s = val_q - W'(1);
                wrap_s     = (val_q == VAL_ZERO);
            end
            MODE_BOUNCE: begin
                step_val_s = go_up_s ? (val_q + W'(1)) : (val_q - W'(1));
                if (step_val_s == VAL_MAX) begin
                    step_dir_s = 1'b0;
                    wrap_s     = 1'b1;
                end else if (step_val_s == VAL_ZERO) begin
                    step_dir_s = 1'b1;
                    wrap_s     = 1'b1;
                end else begin
                    step_dir_s = go_up_s;
                end
            end
            MODE_RING: begin
                if (val_q == VAL_ZERO) begin
                    step_val_s = W'(1);
                end else begin
                    step_val_s = {val_q[W-2:0], val_q[W-1]};
                    wrap_s     = val_q[W-1];
                end
            end
            default: begin
                step_val_s = val_q;
            end
        endcase
    end

    // Mode advance has priority over a coincident tick, which is then dropped.
    always_comb begin
        tc_d     = tc_q;
        mode_d   = mode_q;
        val_d    = val_q;
        dir_up_d = dir_up_q;
        hold_d   = hold_q;
        if (press_q) begin
            mode_d = mode_e'(mode_q + 2'd1);
            tc_d   = TC_ZERO;
            if (mode_d == MODE_RING) begin
                val_d = W'(1);
            end else begin
                val_d = val_q;
            end
            if (mode_d == MODE_BOUNCE) begin
                dir_up_d = 1'b1;
            end else begin
                dir_up_d = dir_up_q;
            end
        end else if (sw_s) begin
            if (tc_q == TC_LAST) begin
                tc_d     = TC_ZERO;
                val_d    = step_val_s;
                dir_up_d = step_dir_s;
                if (wrap_s) begin
                    hold_d = HOLD_LOAD;
                end else if (hold_q != HOLD_ZERO) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else begin
                    hold_d = hold_q;
                end
            end else begin
                tc_d = tc_q + TC_W'(1);
            end
        end else begin
            tc_d = tc_q;
        end
        ledg_d = {(hold_d != HOLD_ZERO), val_d};
    end

    // State registers, cleared by the synchronised reset.
    always_ff @(posedge EXTCLK or negedge rst_n_s) begin
        if (!rst_n_s) begin
            sw_sync_q   <= 2'b00;
            key_sync_q  <= 2'b11;
            deb_level_q <= 1'b1;
            deb_cnt_q   <= DEB_ZERO;
            press_q     <= 1'b0;
            tc_q        <= TC_ZERO;
            mode_q      <= MODE_UP;
            val_q       <= VAL_ZERO;
            dir_up_q    <= 1'b1;
            hold_q      <= HOLD_ZERO;
            ledg_q      <= {LEDG_SIZE{1'b0}};
        end else begin
            sw_sync_q   <= sw_sync_d;
            key_sync_q  <= key_sync_d;
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
            press_q     <= press_d;
            tc_q        <= tc_d;
            mode_q      <= mode_d;
            val_q       <= val_d;
            dir_up_q    <= dir_up_d;
            hold_q      <= hold_d;
            ledg_q      <= ledg_d;
        end
    end
endmodule

// File: tb/tb_led_pattern_counter_top.sv
// Scoreboard bench: a behavioural model predicts every LEDG change and its
// cycle; a monitor compares each observed change against the queued prediction.
module tb_led_pattern_counter_top;
    localparam int EXT_CLOCK_FREQ = 1000;
    localparam int TICK_HZ        = 100;
    localparam int LEDG_SIZE      = 8;
    localparam int DEBOUNCE_MS    = 5;
    localparam int OVF_HOLD_TICKS = 2;
    localparam int TICK_DIV       = EXT_CLOCK_FREQ / TICK_HZ;
    localparam int DEB_CYCLES     = (EXT_CLOCK_FREQ / 1000) * DEBOUNCE_MS;
    localparam int W              = LEDG_SIZE - 1;
    localparam int M              = 1 << W;

    typedef struct {
        int                   cyc;
        logic [LEDG_SIZE-1:0] v;
    } exp_t;

    logic                 clk = 1'b0;
    logic [1:0]           key;
    logic                 sw;
    logic [LEDG_SIZE-1:0] ledg;
    int                   cyc = 0;
    int                   checks = 0;
    int                   errors = 0;
    exp_t                 exp_q[$];

    led_pattern_counter_top #(
        .EXT_CLOCK_FREQ(EXT_CLOCK_FREQ),
        .TICK_HZ(TICK_HZ),
        .LEDG_SIZE(LEDG_SIZE),
        .DEBOUNCE_MS(DEBOUNCE_MS),
        .OVF_HOLD_TICKS(OVF_HOLD_TICKS)
    ) dut (
        .EXTCLK(clk),
        .KEY(key),
        .SW(sw),
        .LEDG(ledg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state (plain integers).
    int   m_mode, m_val, m_tc, m_hold, m_run, m_rel;
    bit   m_up, m_deb, m_press;
    bit   m_sw_p[2];
    bit   m_key_p[2];
    logic [LEDG_SIZE-1:0] m_last = '0;

    function automatic void model_reset();
        m_mode = 0; m_val = 0; m_tc = 0; m_hold = 0; m_run = 0; m_rel = 0;
        m_up = 1'b1; m_deb = 1'b1; m_press = 1'b0;
        m_sw_p[0] = 1'b0; m_sw_p[1] = 1'b0;
        m_key_p[0] = 1'b1; m_key_p[1] = 1'b1;
    endfunction

    function automatic void model_tick();
        bit wrap;
        wrap = 1'b0;
        case (m_mode)
            0: begin wrap = (m_val == M - 1); m_val = (m_val + 1) % M; end
            1: begin wrap = (m_val == 0); m_val = (m_val + M - 1) % M; end
            2: begin
                if (m_val == M - 1) m_up = 1'b0;
                else if (m_val == 0) m_up = 1'b1;
                m_val = m_up ? m_val + 1 : m_val - 1;
                if (m_val == M - 1 || m_val == 0) begin
                    wrap = 1'b1;
                    m_up = (m_val == 0);
                end
            end
            default: begin
                if (m_val == 0) m_val = 1;
                else begin
                    wrap  = (m_val >= M / 2);
                    m_val = (m_val * 2) % M + (wrap ? 1 : 0);
                end
            end
        endcase
        if (wrap) m_hold = OVF_HOLD_TICKS;
        else if (m_hold > 0) m_hold = m_hold - 1;
    endfunction

    // One functional clock edge, from the inputs seen before that edge.
    function automatic void model_func();
        bit sw_now, key_now, new_press;
        sw_now  = m_sw_p[1];
        key_now = m_key_p[1];
        if (m_press) begin
            m_mode = (m_mode + 1) % 4;
            m_tc   = 0;
            if (m_mode == 3) m_val = 1;
            if (m_mode == 2) m_up = 1'b1;
        end else if (sw_now) begin
            m_tc = m_tc + 1;
            if (m_tc == TICK_DIV) begin
                m_tc = 0;
                model_tick();
            end
        end
        new_press = 1'b0;
        if (key_now != m_deb) begin
            m_run = m_run + 1;
            if (m_run == DEB_CYCLES) begin
                m_deb     = key_now;
                m_run     = 0;
                new_press = (key_now == 1'b0);
            end
        end else begin
            m_run = 0;
        end
        m_press    = new_press;
        m_sw_p[1]  = m_sw_p[0];
        m_sw_p[0]  = sw;
        m_key_p[1] = m_key_p[0];
        m_key_p[0] = key[1];
    endfunction

    // Model: at each falling edge predict LEDG after the next rising edge.
    initial begin
        logic [LEDG_SIZE-1:0] e;
        int when;
        exp_t item;
        model_reset();
        forever begin
            @(negedge clk);
            if (key[0] == 1'b0) begin
                model_reset();
                when = cyc;
            end else begin
                when = cyc + 1;
                if (m_rel < 2) m_rel = m_rel + 1;
                else model_func();
            end
            e = {(m_hold != 0), W'(m_val)};
            if (e != m_last) begin
                m_last   = e;
                item.cyc = when;
                item.v   = e;
                exp_q.push_back(item);
            end
        end
    end

    // Monitor: every observed LEDG change pops one prediction (±1 cycle slack).
    initial begin
        logic [LEDG_SIZE-1:0] seen;
        exp_t e;
        seen = '0;
        @(negedge clk); #1;
        checks++;
        if (ledg !== '0) begin
            errors++;
            $display("FAIL reset_state: LEDG=%h, required 00", ledg);
        end
        forever begin
            if (ledg !== seen) begin
                seen = ledg;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: LEDG=%h at cycle %0d, no change predicted", ledg, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (ledg !== e.v || cyc > e.cyc + 1 || cyc + 1 < e.cyc) begin
                        errors++;
                        $display("FAIL ledg_change: LEDG=%h at cycle %0d, required %h at cycle %0d",
                                 ledg, cyc, e.v, e.cyc);
                    end
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc + 1 < cyc) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_change: LEDG=%h at cycle %0d, required %h at cycle %0d",
                         ledg, cyc, e.v, e.cyc);
            end
            @(negedge clk); #1;
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #2;
    endtask

    task automatic press();
        key[1] = 1'b0;
        cycles(DEB_CYCLES + 6);
        key[1] = 1'b1;
        cycles(DEB_CYCLES + 6);
    endtask

    task automatic bouncy_press();
        for (int i = 0; i < 10; i++) begin
            key[1] = ~key[1];
            cycles(2);
        end
        press();
    endtask

    // Stimulus: directed scenarios followed by a randomized mix.
    initial begin
        int r;
        key = 2'b11;
        sw  = 1'b0;
        #1;
        key[0] = 1'b0;
        sw     = 1'b1;
        cycles(5);
        key[0] = 1'b1;
        cycles(TICK_DIV * 5 + 6);
        sw = 1'b0;
        cycles(50);
        sw = 1'b1;
        cycles(TICK_DIV * 130);
        bouncy_press();
        cycles(TICK_DIV * 3);
        press();
        cycles(TICK_DIV * 140);
        press();
        cycles(TICK_DIV * 12);
        key[0] = 1'b0;
        cycles(3);
        key[0] = 1'b1;
        cycles(TICK_DIV * 4);
        for (int it = 0; it < 250; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60) begin
                cycles(int'($urandom_range(1, 40)));
            end else if (r < 75) begin
                sw = ~sw;
                cycles(int'($urandom_range(1, 20)));
            end else if (r < 88) begin
                press();
            end else if (r < 96) begin
                bouncy_press();
            end else begin
                key[0] = 1'b0;
                cycles(int'($urandom_range(1, 3)));
                key[0] = 1'b1;
                cycles(int'($urandom_range(1, 10)));
            end
        end
        cycles(20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predicted changes never observed, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
